// File: rtl/ms_countdown_timer_if.sv
// ----------------------------------------------------------------------------
// ms_countdown_timer_if
//
// Purpose: groups the command strobe and status signals of the millisecond
// countdown timer so the CPU-side bus logic and the timer share one port.
//
// Signals:
//   config_en   one-cycle command strobe; the command bits below are only
//               sampled on a clk edge where config_en is high
//   load        command: load load_value and stop the timer
//   start       command: start or resume the countdown
//   pause       command: freeze the countdown
//   ack         command: clear the expired flag
//   load_value  duration in milliseconds, used with load
//   count       remaining milliseconds (registered)
//   busy        high while running or paused
//   expired     sticky flag, set when the countdown reaches zero
//   state_dbg   current FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
//
// Handshake: there is no ready/valid pair. A command is accepted
// unconditionally on every edge where config_en is high; the master must
// hold config_en high for exactly one cycle per command. Status outputs are
// always valid and may be polled at any time.
//
// Modports: master (CPU / bus side), slave (timer side).
// ----------------------------------------------------------------------------
interface ms_countdown_timer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  config_en;
    logic                  load;
    logic                  start;
    logic                  pause;
    logic                  ack;
    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] count;
    logic                  busy;
    logic                  expired;
    logic [1:0]            state_dbg;

    modport master (
        output config_en, load, start, pause, ack, load_value,
        input  count, busy, expired, state_dbg
    );

    modport slave (
        input  config_en, load, start, pause, ack, load_value,
        output count, busy, expired, state_dbg
    );
endinterface

// File: rtl/ms_countdown_timer.sv
// ----------------------------------------------------------------------------
// ms_countdown_timer
//
// Purpose: millisecond countdown timer. The CPU loads a duration in ms,
// starts the timer, and polls a sticky expired flag which it acknowledges.
// A prescaler divides clk down to a 1 ms tick; each tick decrements count.
//
// Parameters:
//   DATA_WIDTH    width of load_value and count (must match the interface)
//   TICKS_PER_MS  clk cycles per millisecond, >= 2
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset_n   synchronous active-low reset
//   bus       ms_countdown_timer_if.slave: command strobe, load value and
//             count / busy / expired / state_dbg status
//
// Build option:
//   MS_COUNTDOWN_AUTO_RELOAD_EN  when defined, a reload register captures
//   load_value on every load and a terminal tick in RUN reloads count and
//   keeps running (periodic timer). A zero reload value behaves as one-shot.
// ----------------------------------------------------------------------------
module ms_countdown_timer #(
    parameter int DATA_WIDTH   = 16,
    parameter int TICKS_PER_MS = 50000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ms_countdown_timer_if.slave      bus
);

    localparam int PW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;

    localparam logic [PW-1:0]         TICK_LAST  = PW'(TICKS_PER_MS - 1);
    localparam logic [PW-1:0]         PRESC_ONE  = PW'(1);
    localparam logic [DATA_WIDTH-1:0] COUNT_ONE  = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  expired_q, expired_d;

    // Decoded commands: only the highest-priority asserted command is live.
    logic cmd_load;
    logic cmd_ack;
    logic cmd_pause;
    logic cmd_start;

    assign cmd_load  = bus.config_en & bus.load;
    assign cmd_ack   = bus.config_en & ~bus.load & bus.ack;
    assign cmd_pause = bus.config_en & ~bus.load & ~bus.ack & bus.pause;
    assign cmd_start = bus.config_en & ~bus.load & ~bus.ack & ~bus.pause
                     & bus.start;

    // 1 ms boundary; only meaningful while running.
    logic tick;
    assign tick = (state_q == ST_RUN) && (presc_q == TICK_LAST);

    // Reload source. Without the option there is no register and a terminal
    // tick always finishes the countdown.
    logic                  reload_active;
    logic [DATA_WIDTH-1:0] reload_val;

`ifdef MS_COUNTDOWN_AUTO_RELOAD_EN
    logic [DATA_WIDTH-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else if (cmd_load) begin
            reload_q <= bus.load_value;
        end
    end

    assign reload_active = (reload_q != '0);
    assign reload_val    = reload_q;
`else
    assign reload_active = 1'b0;
    assign reload_val    = '0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        expired_d = expired_q;

        if (cmd_load) begin
            // load wins over everything, including a tick on this edge.
            count_d   = bus.load_value;
            presc_d   = '0;
            expired_d = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_ack) begin
                        expired_d = 1'b0;
                    end
                    if (cmd_start) begin
                        if (count_q != '0) begin
                            state_d = ST_RUN;
                            presc_d = '0;
                        end else begin
                            // Zero-length timeout expires immediately.
                            state_d   = ST_DONE;
                            expired_d = 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    presc_d = tick ? '0 : (presc_q + PRESC_ONE);
                    if (cmd_ack) begin
                        expired_d = 1'b0;
                    end
                    if (cmd_pause) begin
                        state_d = ST_PAUSE;
                    end
                    // The tick is applied even when pause arrives on the same
                    // edge; a terminal tick then overrides the pause target.
                    // A terminal tick also overrides a same-edge ack so a new
                    // expiry is never lost.
                    if (tick) begin
                        if (count_q == COUNT_ONE) begin
                            expired_d = 1'b1;
                            if (reload_active) begin
                                count_d = reload_val;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - COUNT_ONE;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (cmd_ack) begin
                        expired_d = 1'b0;
                    end
                    // Prescaler is left untouched so no partial ms is lost.
                    if (cmd_start) begin
                        state_d = ST_RUN;
                    end
                end

                ST_DONE: begin
                    if (cmd_ack) begin
                        state_d   = ST_IDLE;
                        expired_d = 1'b0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.count     = count_q;
    assign bus.expired   = expired_q;
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ms_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_ms_countdown_timer
//
// Self-checking bench for ms_countdown_timer with TICKS_PER_MS = 4.
// A table of per-edge vectors covers the one-shot countdown, zero load,
// command priority and load-on-tick; hand-written sequences cover reset
// mid-countdown, pause/resume, pause on the terminal tick and, when
// MS_COUNTDOWN_AUTO_RELOAD_EN is defined, periodic reload.
// ----------------------------------------------------------------------------
module tb_ms_countdown_timer;

    localparam int DW    = 16;
    localparam int TICKS = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef MS_COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ms_countdown_timer_if #(.DATA_WIDTH(DW)) bus ();

    ms_countdown_timer #(
        .DATA_WIDTH   (DW),
        .TICKS_PER_MS (TICKS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req,
                     $time);
        end
    endtask

    task automatic check_all(input string name, input logic [DW-1:0] e_count,
                             input logic e_busy, input logic e_exp,
                             input logic [1:0] e_state);
        check({name, ".count"},   32'(bus.count),     32'(e_count));
        check({name, ".busy"},    32'(bus.busy),      32'(e_busy));
        check({name, ".expired"}, 32'(bus.expired),   32'(e_exp));
        check({name, ".state"},   32'(bus.state_dbg), 32'(e_state));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.config_en  = 1'b0;
        bus.load       = 1'b0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.ack        = 1'b0;
        bus.load_value = '0;
    endtask

    // Advance n edges; returns 1 time unit after the last edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle command strobe; returns just after the edge that sampled it.
    task automatic cmd(input logic l, input logic s, input logic p,
                       input logic a, input logic [DW-1:0] v);
        bus.config_en  = 1'b1;
        bus.load       = l;
        bus.start      = s;
        bus.pause      = p;
        bus.ack        = a;
        bus.load_value = v;
        cycles(1);
        idle_inputs();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          cfg;
        logic          ld;
        logic          st;
        logic          pa;
        logic          ak;
        logic [DW-1:0] val;
        logic [DW-1:0] e_count;
        logic          e_busy;
        logic          e_exp;
        logic [1:0]    e_state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cfg, input logic ld, input logic st,
                       input logic pa, input logic ak, input logic [DW-1:0] val,
                       input logic [DW-1:0] e_count, input logic e_busy,
                       input logic e_exp, input logic [1:0] e_state);
        vec_t v;
        v.cfg = cfg; v.ld = ld; v.st = st; v.pa = pa; v.ak = ak; v.val = val;
        v.e_count = e_count; v.e_busy = e_busy; v.e_exp = e_exp;
        v.e_state = e_state;
        vecs.push_back(v);
    endtask

    task automatic build_table();
        // One-shot: load 3, start edge E0, decrements at E4, E8, E12.
        add(1, 1, 0, 0, 0, 16'd3,  16'd3, 0, 0, S_IDLE);
        add(1, 0, 1, 0, 0, 16'd0,  16'd3, 1, 0, S_RUN);   // E0
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 16'd3, 1, 0, S_RUN);
        add(0, 0, 0, 0, 0, 16'd0,  16'd2, 1, 0, S_RUN);   // E4
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 16'd2, 1, 0, S_RUN);
        add(0, 0, 0, 0, 0, 16'd0,  16'd1, 1, 0, S_RUN);   // E8
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 16'd1, 1, 0, S_RUN);
        if (AUTO) begin
            // Periodic: reload 3, keep running; ack clears expired only.
            add(0, 0, 0, 0, 0, 16'd0, 16'd3, 1, 1, S_RUN);   // E12
            add(1, 0, 1, 0, 0, 16'd0, 16'd3, 1, 1, S_RUN);
            add(1, 0, 0, 0, 1, 16'd0, 16'd3, 1, 0, S_RUN);
        end else begin
            add(0, 0, 0, 0, 0, 16'd0, 16'd0, 0, 1, S_DONE);  // E12
            add(1, 0, 1, 0, 0, 16'd0, 16'd0, 0, 1, S_DONE);  // start ignored
            add(1, 0, 0, 0, 1, 16'd0, 16'd0, 0, 0, S_IDLE);  // ack
        end
        // Zero load then start expires on the start edge.
        add(1, 1, 0, 0, 0, 16'd0,  16'd0, 0, 0, S_IDLE);
        add(1, 0, 1, 0, 0, 16'd0,  16'd0, 0, 1, S_DONE);
        add(1, 0, 0, 0, 1, 16'd0,  16'd0, 0, 0, S_IDLE);
        // load + start in one strobe: load wins.
        add(1, 1, 1, 0, 0, 16'd9,  16'd9, 0, 0, S_IDLE);
        add(1, 0, 0, 0, 1, 16'd0,  16'd9, 0, 0, S_IDLE);  // ack no effect
        add(1, 0, 0, 1, 0, 16'd0,  16'd9, 0, 0, S_IDLE);  // pause no effect
        // load on a tick edge: no decrement.
        add(1, 0, 1, 0, 0, 16'd0,  16'd9, 1, 0, S_RUN);   // presc 0
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 16'd9, 1, 0, S_RUN);
        add(1, 1, 0, 0, 0, 16'd6,  16'd6, 0, 0, S_IDLE);  // tick edge
        // Priority pause > start, ack > start.
        add(1, 0, 1, 0, 0, 16'd0,  16'd6, 1, 0, S_RUN);   // presc 0
        add(1, 0, 1, 1, 0, 16'd0,  16'd6, 1, 0, S_PAUSE); // presc 1
        add(1, 0, 1, 0, 1, 16'd0,  16'd6, 1, 0, S_PAUSE); // ack wins
        add(1, 0, 1, 0, 0, 16'd0,  16'd6, 1, 0, S_RUN);   // resume at 1
        add(0, 0, 0, 0, 0, 16'd0,  16'd6, 1, 0, S_RUN);   // 2
        add(0, 0, 0, 0, 0, 16'd0,  16'd6, 1, 0, S_RUN);   // 3
        add(0, 0, 0, 0, 0, 16'd0,  16'd5, 1, 0, S_RUN);   // tick
        // Commands without config_en are ignored.
        add(0, 1, 0, 0, 0, 16'd100, 16'd5, 1, 0, S_RUN);
    endtask

    // ---------------- test ----------------
    initial begin
        idle_inputs();
        reset_n = 1'b0;
        cycles(2);
        check_all("reset", 16'd0, 0, 0, S_IDLE);
        reset_n = 1'b1;
        cycles(1);

        build_table();
        foreach (vecs[i]) begin
            bus.config_en  = vecs[i].cfg;
            bus.load       = vecs[i].ld;
            bus.start      = vecs[i].st;
            bus.pause      = vecs[i].pa;
            bus.ack        = vecs[i].ak;
            bus.load_value = vecs[i].val;
            cycles(1);
            check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy,
                      vecs[i].e_exp, vecs[i].e_state);
        end
        idle_inputs();

        // Reset mid-countdown aborts with no expiry.
        cmd(1, 0, 0, 0, 16'd7);
        cmd(0, 1, 0, 0, 16'd0);
        cycles(2);
        check_all("pre_reset", 16'd7, 1, 0, S_RUN);
        reset_n = 1'b0;
        cycles(1);
        check_all("mid_reset", 16'd0, 0, 0, S_IDLE);
        cycles(1);
        reset_n = 1'b1;
        cycles(8);
        check_all("post_reset", 16'd0, 0, 0, S_IDLE);

        // Pause/resume: pause on E6 holds count 4 with prescaler 2.
        cmd(1, 0, 0, 0, 16'd5);
        cmd(0, 1, 0, 0, 16'd0);           // E0
        cycles(5);                        // E1..E5
        cmd(0, 0, 1, 0, 16'd0);           // E6
        check_all("pause", 16'd4, 1, 0, S_PAUSE);
        cycles(20);
        check_all("pause_hold", 16'd4, 1, 0, S_PAUSE);
        exp_q.push_back(16'd4);
        exp_q.push_back(16'd4);
        exp_q.push_back(16'd3);
        cmd(0, 1, 0, 0, 16'd0);
        check("resume.state", 32'(bus.state_dbg), 32'(S_RUN));
        check("resume.c0", 32'(bus.count), 32'(exp_q.pop_front()));
        cycles(1);
        check("resume.c1", 32'(bus.count), 32'(exp_q.pop_front()));
        cycles(1);
        check("resume.c2", 32'(bus.count), 32'(exp_q.pop_front()));

        // Pause strobed on the terminal tick.
        cmd(1, 0, 0, 0, 16'd1);
        cmd(0, 1, 0, 0, 16'd0);           // E0
        cycles(3);
        cmd(0, 0, 1, 0, 16'd0);           // E4 tick
        if (AUTO) begin
            check_all("pause_term", 16'd1, 1, 1, S_PAUSE);
            cmd(0, 1, 0, 0, 16'd0);
            check_all("pause_term_start", 16'd1, 1, 1, S_RUN);
        end else begin
            check_all("pause_term", 16'd0, 0, 1, S_DONE);
            cmd(0, 1, 0, 0, 16'd0);
            check_all("pause_term_start", 16'd0, 0, 1, S_DONE);
        end

`ifdef MS_COUNTDOWN_AUTO_RELOAD_EN
        // Periodic: load 2, expiry every 8 cycles, ack does not stop it.
        cmd(1, 0, 0, 0, 16'd2);
        cmd(0, 1, 0, 0, 16'd0);           // E0
        cycles(7);                        // E7
        check_all("auto_e7", 16'd1, 1, 0, S_RUN);
        cycles(1);                        // E8
        check_all("auto_e8", 16'd2, 1, 1, S_RUN);
        cmd(0, 0, 0, 1, 16'd0);           // E9
        check_all("auto_e9", 16'd2, 1, 0, S_RUN);
        cycles(6);                        // E15
        check_all("auto_e15", 16'd1, 1, 0, S_RUN);
        cycles(1);                        // E16
        check_all("auto_e16", 16'd2, 1, 1, S_RUN);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ms_countdown_timer.md
Name: ms_countdown_timer

Overview:
- Millisecond countdown timer, the complement of the free-running millisecond up-counter.
- The CPU writes a millisecond duration through the memory-mapped config strobe. The block counts down to zero and raises a sticky expired flag, which the CPU polls and acknowledges.
- Sits on the same peripheral bus as the millisecond counter. Used for game-round timeouts and delays.

Parameters:
- DATA_WIDTH, 16, width of load value and count.
- TICKS_PER_MS, 50000, clk cycles per millisecond (50 MHz clock). Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  system reset; synchronous, active-low.
- config_en  input  1  one-cycle command strobe; command inputs are sampled only when high.
- load  input  1  command: load load_value, stop timer.
- start  input  1  command: start or resume countdown.
- pause  input  1  command: freeze countdown.
- ack  input  1  command: clear expired flag.
- load_value  input  DATA_WIDTH  duration in ms, used with load.
- count  output  DATA_WIDTH  remaining ms.
- busy  output  1  high in RUN or PAUSE.
- expired  output  1  sticky; high once count reaches 0 via countdown.

Behaviour:
- Reset: reset_n low at a clk edge sets state=IDLE, count=0, prescaler=0, expired=0, busy=0. Reset mid-countdown aborts immediately with no expiry.
- Prescaler: internal counter of width clog2(TICKS_PER_MS).
  - Increments only in RUN.
  - A tick occurs on the edge where prescaler==TICKS_PER_MS-1; prescaler wraps to 0 and count decrements by 1.
- Command priority, when config_en=1: load > ack > pause > start. Only the highest asserted command is acted on. Commands with config_en=0 are ignored.
- load (any state):
  - count<=load_value, prescaler<=0, expired<=0, state<=IDLE.
  - Overrides a same-cycle tick.
- States:
  - IDLE: count holds.
    - start with count!=0 -> RUN, prescaler<=0.
    - start with count==0 -> DONE, expired<=1 on the same edge.
    - pause and ack have no effect.
  - RUN:
    - Each edge, prescaler advances.
    - On a tick with count==1: count<=0, expired<=1, state<=DONE, all on the same edge.
    - pause -> PAUSE. A tick on the same edge is still applied (count decrements, or expires if count==1, in which case state is DONE not PAUSE).
    - start has no effect.
  - PAUSE: prescaler and count hold.
    - start -> RUN, resuming from the held prescaler value (no partial-ms loss).
  - DONE: count=0, expired=1 held indefinitely.
    - ack -> IDLE, expired<=0.
    - start has no effect until load or ack.
- ack outside DONE: clears expired if set (auto-reload case), otherwise no effect.
- No underflow: count never decrements below 0.
- busy is combinational from state.
- count and expired are registered.
- Latency: expired rises exactly load_value*TICKS_PER_MS cycles after the start edge when uninterrupted.

Optional Feature:
- Macro: MS_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - A reload register captures load_value on every load (reset value 0).
  - On a terminal tick in RUN: count<=reload, expired<=1, state stays RUN, prescaler wraps to 0. This gives a periodic timer.
  - expired stays sticky until ack; ack does not stop the timer.
  - If reload==0, behaviour matches the undefined case (-> DONE).
  - start with count==0 in IDLE still -> DONE.
- Undefined: no reload register; behaviour as above (one-shot, stops in DONE).

Test Plan:
All cases use TICKS_PER_MS=4, DATA_WIDTH=16.
- Reset: reset_n=0 for 2 cycles during RUN with count=7 -> count=0, busy=0, expired=0 on the next edge; stays idle after release.
- One-shot: load 3, then start -> busy=1; count 3->2->1->0 at 4-cycle intervals; expired=1 and busy=0 exactly 12 cycles after the start edge; ack -> expired=0, state IDLE.
- Pause/resume: load 5, start, run 6 cycles (count=4, prescaler=2), pause for 20 cycles -> count stays 4. Start -> next decrement after 2 cycles.
- Zero/priority:
  - load 0 then start -> expired=1 on that edge.
  - load+start in the same strobe -> load wins, state IDLE, count=load_value.
  - load during RUN on a tick edge -> count=load_value, no decrement.
- Pause coinciding with terminal tick: count=1, pause strobed on the tick edge -> count=0, expired=1, state DONE; a subsequent start is ignored.
- MS_COUNTDOWN_AUTO_RELOAD_EN: load 2, start -> expired=1 at cycle 8, count=2, busy=1. Ack at cycle 9 -> expired=0; expired=1 again at cycle 16.
